reg_file_master: RTL and testbench

//  Command-driven initiator for the 8x16 register file: accepts WRITE/READ/RMW-add

---
 rtl/regm_pkg.sv | 34 +++
 rtl/reg_file_master.sv | 146 ++++++++++++++
 tb/tb_reg_file_master.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regm_pkg.sv
// Shared types for the register-file command master.
// REGM_RMW_EN builds the read-modify-write add path.
package regm_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_RMW   = 2'b10,
        OP_ILL   = 2'b11
    } regm_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
`ifdef REGM_RMW_EN
        S_WB   = 3'd4,
`endif
        S_RESP = 3'd5
    } regm_state_e;

    localparam int unsigned RSP_WR_DATA = 0;

    // Opcodes that start with a register read.
    function automatic logic op_reads(input regm_op_e op);
`ifdef REGM_RMW_EN
        return (op == OP_READ) || (op == OP_RMW);
`else
        return (op == OP_READ);
`endif
    endfunction

endpackage

// File: rtl/reg_file_master.sv
// Command-driven initiator for the 8x16 register file.
// Define REGM_RMW_EN to enable opcode 10 as read-modify-write add.
module reg_file_master
    import regm_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_OP,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_DATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_ERR,
    output logic              RF_RD_EN,
    output logic              RF_WR_EN,
    output logic [ADDR_W-1:0] RF_ADDR,
    output logic [DATA_W-1:0] RF_WR_DATA,
    input  logic [DATA_W-1:0] RF_RD_DATA,
    output logic              BUSY
);

    regm_state_e state;
    logic        op_wr;
    logic        op_rd;

`ifdef REGM_RMW_EN
    logic              rmw_q;
    logic [DATA_W-1:0] addend_q;
`endif

    assign op_wr = (regm_op_e'(CMD_OP) == OP_WRITE);
    assign op_rd = op_reads(regm_op_e'(CMD_OP));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            CMD_READY  <= 1'b1;
            RSP_VALID  <= 1'b0;
            RSP_DATA   <= '0;
            RSP_ERR    <= 1'b0;
            RF_RD_EN   <= 1'b0;
            RF_WR_EN   <= 1'b0;
            RF_ADDR    <= '0;
            RF_WR_DATA <= '0;
            BUSY       <= 1'b0;
`ifdef REGM_RMW_EN
            rmw_q      <= 1'b0;
            addend_q   <= '0;
`endif
        end else begin
            // Strobes last one cycle unless re-armed below.
            RF_RD_EN   <= 1'b0;
            RF_WR_EN   <= 1'b0;
            RF_WR_DATA <= '0;
            case (state)
                S_IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        CMD_READY <= 1'b0;
                        BUSY      <= 1'b1;
                        RF_ADDR   <= CMD_ADDR;
`ifdef REGM_RMW_EN
                        rmw_q     <= (regm_op_e'(CMD_OP) == OP_RMW);
                        addend_q  <= CMD_DATA;
`endif
                        unique case (1'b1)
                            op_wr: begin
                                state      <= S_WR;
                                RF_WR_EN   <= 1'b1;
                                RF_WR_DATA <= CMD_DATA;
                            end
                            op_rd: begin
                                state    <= S_RD;
                                RF_RD_EN <= 1'b1;
                            end
                            default: begin
                                state     <= S_RESP;
                                RSP_VALID <= 1'b1;
                                RSP_ERR   <= 1'b1;
                                RSP_DATA  <= '0;
                            end
                        endcase
                    end
                end
                S_WR: begin
                    state     <= S_RESP;
                    RSP_VALID <= 1'b1;
                    RSP_DATA  <= DATA_W'(RSP_WR_DATA);
                end
                S_RD: begin
                    state <= S_CAP;
                end
                S_CAP: begin
                    // The file drives data only in this cycle.
                    RSP_DATA <= RF_RD_DATA;
`ifdef REGM_RMW_EN
                    if (rmw_q) begin
                        state      <= S_WB;
                        RF_WR_EN   <= 1'b1;
                        RF_WR_DATA <= RF_RD_DATA + addend_q;
                    end else begin
                        state     <= S_RESP;
                        RSP_VALID <= 1'b1;
                    end
`else
                    state     <= S_RESP;
                    RSP_VALID <= 1'b1;
`endif
                end
`ifdef REGM_RMW_EN
                S_WB: begin
                    state     <= S_RESP;
                    RSP_VALID <= 1'b1;
                end
`endif
                S_RESP: begin
                    if (RSP_READY) begin
                        state     <= S_IDLE;
                        RSP_VALID <= 1'b0;
                        RSP_DATA  <= '0;
                        RSP_ERR   <= 1'b0;
                        CMD_READY <= 1'b1;
                        BUSY      <= 1'b0;
                        RF_ADDR   <= '0;
`ifdef REGM_RMW_EN
                        rmw_q     <= 1'b0;
                        addend_q  <= '0;
`endif
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    RSP_VALID <= 1'b0;
                    CMD_READY <= 1'b1;
                    BUSY      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_master.sv
// Directed and scoreboard bench for reg_file_master.
// Models the registered-read 8x16 register file locally.
module tb_reg_file_master;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          CMD_VALID = 1'b0;
    logic          CMD_READY;
    logic [1:0]    CMD_OP = 2'b00;
    logic [AW-1:0] CMD_ADDR = '0;
    logic [DW-1:0] CMD_DATA = '0;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b0;
    logic [DW-1:0] RSP_DATA;
    logic          RSP_ERR;
    logic          RF_RD_EN;
    logic          RF_WR_EN;
    logic [AW-1:0] RF_ADDR;
    logic [DW-1:0] RF_WR_DATA;
    logic [DW-1:0] RF_RD_DATA;
    logic          BUSY;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [8];
    logic [DW-1:0] sb  [8];
    logic [DW-1:0] rd_q;
    logic          rf_seen;

    reg_file_master #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .RF_RD_EN(RF_RD_EN), .RF_WR_EN(RF_WR_EN),
        .RF_ADDR(RF_ADDR), .RF_WR_DATA(RF_WR_DATA),
        .RF_RD_DATA(RF_RD_DATA), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Register file: registered read, zero when not enabled.
    always @(posedge CLK) begin
        if (RF_WR_EN) mem[RF_ADDR] <= RF_WR_DATA;
        rd_q <= RF_RD_EN ? mem[RF_ADDR] : '0;
    end
    assign RF_RD_DATA = rd_q;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST) chk("rf_excl", 32'(RF_RD_EN & RF_WR_EN), 0);
        if (RF_RD_EN || RF_WR_EN) rf_seen = 1'b1;
    end

    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int hold,
                           output logic [DW-1:0] rdata,
                           output logic err, output int lat);
        int g;
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_ADDR  = a;
        CMD_DATA  = d;
        g = 0;
        while (!CMD_READY && g < 20) begin
            @(negedge CLK);
            g++;
        end
        if (g >= 20) chk("accept_timeout", 1, 0);
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        lat = 1;
        while (!RSP_VALID && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        if (!RSP_VALID) chk("rsp_timeout", 1, 0);
        rdata = RSP_DATA;
        err   = RSP_ERR;
        for (int k = 0; k < hold; k++) begin
            @(negedge CLK);
            chk("hold_valid", 32'(RSP_VALID), 1);
            chk("hold_data", 32'(RSP_DATA), 32'(rdata));
            chk("hold_ready", 32'(CMD_READY), 0);
        end
        @(negedge CLK);
        RSP_READY = 1'b1;
        @(posedge CLK);
        #1;
        RSP_READY = 1'b0;
        chk("rsp_drop", 32'(RSP_VALID), 0);
        chk("idle_ready", 32'(CMD_READY), 1);
    endtask

    function automatic int exp_lat(input logic [1:0] op);
        case (op)
            2'b00: return 2;
            2'b01: return 3;
`ifdef REGM_RMW_EN
            2'b10: return 4;
`endif
            default: return 1;
        endcase
    endfunction

    logic [DW-1:0] rd;
    logic          er;
    int            lt;

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i] = '0;
            sb[i]  = '0;
        end
        rf_seen = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_ready", 32'(CMD_READY), 1);
        chk("rst_rspv", 32'(RSP_VALID), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_addr", 32'(RF_ADDR), 0);
        RST = 1'b1;
        @(negedge CLK);
        chk("rel_ready", 32'(CMD_READY), 1);

        // 1: write then read back
        run_cmd(2'b00, 3'd3, 16'hA5A5, 0, rd, er, lt);
        chk("wr_data", 32'(rd), 0);
        chk("wr_lat", lt, 2);
        run_cmd(2'b01, 3'd3, 16'h0000, 0, rd, er, lt);
        chk("rd_data", 32'(rd), 32'hA5A5);
        chk("rd_err", 32'(er), 0);
        chk("rd_lat", lt, 3);

        // 2: RMW add wraps past 0xFFFF
        run_cmd(2'b00, 3'd5, 16'hFFFF, 1, rd, er, lt);
        run_cmd(2'b10, 3'd5, 16'h0002, 0, rd, er, lt);
`ifdef REGM_RMW_EN
        chk("rmw_data", 32'(rd), 32'hFFFF);
        chk("rmw_err", 32'(er), 0);
        chk("rmw_lat", lt, 4);
        run_cmd(2'b01, 3'd5, 16'h0000, 0, rd, er, lt);
        chk("rmw_after", 32'(rd), 32'h0001);
`else
        chk("rmw_data", 32'(rd), 0);
        chk("rmw_err", 32'(er), 1);
        chk("rmw_lat", lt, 1);
        run_cmd(2'b01, 3'd5, 16'h0000, 0, rd, er, lt);
        chk("rmw_after", 32'(rd), 32'hFFFF);
`endif

        // 3: illegal opcode touches nothing
        mem[0] = 16'h1234;
        rf_seen = 1'b0;
        run_cmd(2'b11, 3'd0, 16'hBEEF, 0, rd, er, lt);
        chk("ill_err", 32'(er), 1);
        chk("ill_lat", lt, 1);
        chk("ill_rf", 32'(rf_seen), 0);
        run_cmd(2'b01, 3'd0, 16'h0000, 0, rd, er, lt);
        chk("ill_reg0", 32'(rd), 32'h1234);

        // 4: stalled response holds
        run_cmd(2'b01, 3'd3, 16'h0000, 5, rd, er, lt);
        chk("stall_data", 32'(rd), 32'hA5A5);

        // 5: reset during RD drops the command
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_OP    = 2'b01;
        CMD_ADDR  = 3'd3;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        chk("pre_rst_rden", 32'(RF_RD_EN), 1);
        RST = 1'b0;
        #1;
        chk("mid_rst_rden", 32'(RF_RD_EN), 0);
        chk("mid_rst_busy", 32'(BUSY), 0);
        chk("mid_rst_addr", 32'(RF_ADDR), 0);
        chk("mid_rst_ready", 32'(CMD_READY), 1);
        @(negedge CLK);
        RST = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            chk("no_rsp", 32'(RSP_VALID), 0);
        end
        run_cmd(2'b00, 3'd6, 16'h0F0F, 0, rd, er, lt);
        chk("post_wr_lat", lt, 2);
        run_cmd(2'b01, 3'd6, 16'h0000, 0, rd, er, lt);
        chk("post_rd", 32'(rd), 32'h0F0F);

        // 6: random traffic against scoreboard
        for (int i = 0; i < 8; i++) sb[i] = mem[i];
        for (int n = 0; n < 1000; n++) begin
            logic [1:0]    op;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [DW-1:0] e;
            logic          ee;
            op = 2'($urandom_range(0, 3));
            a  = AW'($urandom_range(0, 7));
            d  = DW'($urandom);
            e  = '0;
            ee = 1'b0;
            case (op)
                2'b00: sb[a] = d;
                2'b01: e = sb[a];
`ifdef REGM_RMW_EN
                2'b10: begin
                    e = sb[a];
                    sb[a] = sb[a] + d;
                end
`endif
                default: ee = 1'b1;
            endcase
            run_cmd(op, a, d, $urandom_range(0, 2), rd, er, lt);
            chk("rnd_data", 32'(rd), 32'(e));
            chk("rnd_err", 32'(er), 32'(ee));
            chk("rnd_lat", lt, exp_lat(op));
        end
        for (int i = 0; i < 8; i++) chk("rnd_mem", 32'(mem[i]), 32'(sb[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
